btn_pulse_gen: RTL and testbench



---
 rtl/btn_pulse_gen.sv | 131 +++++++++++++
 tb/tb_btn_pulse_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Conditions a raw push-button into one-cycle count-enable pulses (single press + auto-repeat).
// Latency: x/lvl rise 2+DB_CYCLES edges after btn is first sampled high; there is no backpressure.
module btn_pulse_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int REP_DELAY  = 10,
  parameter int REP_PERIOD = 5,
  parameter int TW         = 8
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  input  logic rep_en,
  output logic x,
  output logic lvl
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam logic [TW-1:0] DB_LAST  = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REP_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REP_PERIOD - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          s1_q, btn_s_q;
  logic          x_q, x_d;
  logic          lvl_q, lvl_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      tmr_q   <= '0;
      x_q     <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      s1_q    <= btn;
      btn_s_q <= s1_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      x_q     <= x_d;
      lvl_q   <= lvl_d;
    end
  end

  // Every state change restarts the timer; a release seen by HELD/REPEAT wins over any pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (btn_s_q) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == DB_LAST) begin
          state_d = HELD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = DB_RELEASE;
          tmr_d   = '0;
        end else if (rep_en && (tmr_q == DLY_LAST)) begin
          state_d = REPEAT;
          tmr_d   = '0;
        end else if (rep_en) begin
          tmr_d = tmr_q + TW'(1);
        end else begin
          tmr_d = '0;
        end
      end
      REPEAT: begin
        if (!btn_s_q) begin
          state_d = DB_RELEASE;
          tmr_d   = '0;
        end else if (!rep_en) begin
          state_d = HELD;
          tmr_d   = '0;
        end else if (tmr_q == PER_LAST) begin
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DB_RELEASE: begin
        if (btn_s_q) begin
          state_d = HELD;
          tmr_d   = '0;
        end else if (tmr_q == DB_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_comb begin
    x_d   = 1'b0;
    lvl_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_RELEASE);
    unique case (state_q)
      DB_PRESS: x_d = btn_s_q && (tmr_q == DB_LAST);
      HELD:     x_d = btn_s_q && rep_en && (tmr_q == DLY_LAST);
      REPEAT:   x_d = btn_s_q && rep_en && (tmr_q == PER_LAST);
      default:  x_d = 1'b0;
    endcase
  end

  assign x   = x_q;
  assign lvl = lvl_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen: expected pulse edges are queued per scenario and popped as x fires.
module tb_btn_pulse_gen;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int TW = 8;
  localparam int NONE = 1000;

  logic clk    = 1'b0;
  logic clr_n  = 1'b0;
  logic btn    = 1'b0;
  logic rep_en = 1'b0;
  logic x;
  logic lvl;

  int checks = 0;
  int errors = 0;
  int edge_k = -100;
  int lvl_rise = NONE;
  int lvl_fall = NONE;
  int exp_q[$];

  btn_pulse_gen #(
    .DB_CYCLES (DB),
    .REP_DELAY (RD),
    .REP_PERIOD(RP),
    .TW        (TW)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (btn),
    .rep_en(rep_en),
    .x     (x),
    .lvl   (lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_k, got, exp);
    end
  endtask

  // Drive btn/clr_n on the falling edge, sample outputs 1 time unit after the rising edge.
  task automatic tick(input logic b, input logic c);
    int e;
    @(negedge clk);
    btn   = b;
    clr_n = c;
    @(posedge clk);
    #1;
    if (x === 1'b1) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("x_pulse_edge", edge_k, e);
    end
    chk("lvl", int'(lvl), ((edge_k >= lvl_rise) && (edge_k < lvl_fall)) ? 1 : 0);
    edge_k++;
  endtask

  task automatic gap(input int n);
    lvl_rise = NONE;
    lvl_fall = NONE;
    edge_k   = -n;
    repeat (n) tick(1'b0, 1'b1);
  endtask

  task automatic start(input int rise, input int fall);
    edge_k   = 0;
    lvl_rise = rise;
    lvl_fall = fall;
  endtask

  task automatic finish_scn(input string tag);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    // Reset held with btn toggling, then 20 quiet cycles.
    #1;
    chk("rst_x", int'(x), 0);
    chk("rst_lvl", int'(lvl), 0);
    for (int i = 0; i < 6; i++) tick(i[0], 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
    finish_scn("rst_no_pulse");

    // Clean press, no repeat: btn high for edges 0..29, released at F=30.
    rep_en = 1'b0;
    gap(5);
    exp_q.push_back(2 + DB);
    start(2 + DB, 30 + 2 + DB);
    for (int k = 0; k < 45; k++) tick(k < 30, 1'b1);
    finish_scn("press_pulses");

    // Glitch: high for edges 0..2 only.
    gap(5);
    start(NONE, NONE);
    for (int k = 0; k < 15; k++) tick(k < 3, 1'b1);
    finish_scn("glitch_pulses");

    // Auto-repeat: btn first sampled low at F=39, so DB_RELEASE at 41 beats the pulse due at 41.
    rep_en = 1'b1;
    gap(5);
    exp_q.push_back(6);
    exp_q.push_back(16);
    exp_q.push_back(21);
    exp_q.push_back(26);
    exp_q.push_back(31);
    exp_q.push_back(36);
    start(6, 45);
    for (int k = 0; k < 55; k++) tick(k < 39, 1'b1);
    finish_scn("repeat_pulses");

    // Release bounce: low at edges 8,9 -> DB_RELEASE at 10, back to HELD at 12, repeats restart.
    // Final release at F=30 enters DB_RELEASE at 32, preempting the repeat due at 32.
    gap(5);
    exp_q.push_back(6);
    exp_q.push_back(12 + RD);
    exp_q.push_back(12 + RD + RP);
    start(6, 30 + 2 + DB);
    for (int k = 0; k < 45; k++) tick((k < 8) || ((k >= 10) && (k < 30)), 1'b1);
    finish_scn("bounce_pulses");

    // Reset asserted asynchronously right after the repeat pulse at edge 21.
    gap(5);
    exp_q.push_back(6);
    exp_q.push_back(16);
    exp_q.push_back(21);
    start(6, NONE);
    for (int k = 0; k < 22; k++) tick(1'b1, 1'b1);
    chk("x_before_rst", int'(x), 1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("x_async_rst", int'(x), 0);
    chk("lvl_async_rst", int'(lvl), 0);
    finish_scn("pre_rst_pulses");
    lvl_rise = NONE;
    lvl_fall = NONE;
    edge_k   = -3;
    repeat (3) tick(1'b1, 1'b0);
    // Edge 0 is the first edge with clr_n high; btn is still held, released at F=12.
    exp_q.push_back(2 + DB);
    start(2 + DB, 12 + 2 + DB);
    for (int k = 0; k < 25; k++) tick(k < 12, 1'b1);
    finish_scn("post_rst_pulses");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
